// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the debounce bank: default dwell and synchronizer
// depth, plus the helper that sizes the per-channel dwell counter.
package debounce_pkg;

    localparam int DEF_DWELL_CNT   = 32'sd50000;
    localparam int DEF_SYNC_STAGES = 32'sd2;

    // Counter width able to hold 0..dwell-1; never narrower than one bit so
    // that a dwell of 1 still elaborates a legal vector.
    function automatic int cnt_width(input int dwell);
        int w;
        w = $clog2(dwell);
        if (w < 32'sd1) begin
            return 32'sd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
// One debounced channel: a SYNC_STAGES-deep synchronizer, a dwell counter
// that must see DWELL_CNT consecutive cycles of disagreement before the
// debounced state follows the input, and one-cycle rise/fall pulses that are
// registered on the same edge as the state flip.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   sig_in  - raw asynchronous input bit
//   sig_out - debounced level
//   rise    - one-cycle pulse coincident with the first cycle of sig_out=1
//   fall    - one-cycle pulse coincident with the first cycle of sig_out=0
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   DWELL_CNT   = DEF_DWELL_CNT,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_out,
    output logic rise,
    output logic fall
);

    localparam int              CW       = cnt_width(DWELL_CNT);
    // Exact terminal value, so non-power-of-two dwells are honoured exactly.
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL_CNT - 32'sd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   state_r;
    logic [CW-1:0]          cnt_r;
    logic                   rise_r;
    logic                   fall_r;

    logic                   state_nxt_s;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   rise_nxt_s;
    logic                   fall_nxt_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Input synchronizer shift chain; bit 0 samples the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Dwell decision: count disagreement, flip on the terminal count, and
    // restart the dwell whenever the input agrees with the current state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = {CW{1'b0}};
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        if (sync_s != state_r) begin
            if (cnt_r == CNT_LAST) begin
                state_nxt_s = sync_s;
                rise_nxt_s  = sync_s;
                fall_nxt_s  = ~sync_s;
            end else begin
                cnt_nxt_s   = cnt_r + CW'(1);
            end
        end else begin
            cnt_nxt_s = {CW{1'b0}};
        end
    end

    // State, counter and pulse registers; reset discards any pending flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RESET_BIT;
            cnt_r   <= {CW{1'b0}};
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    assign sig_out = state_r;
    assign rise    = rise_r;
    assign fall    = fall_r;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank
// CHANNELS independent debouncers plus a lowest-index encoder over the rise
// pulses, so the consumer can service one press per cycle without scanning.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   sig_in   - raw asynchronous inputs, one bit per channel
//   sig_out  - debounced levels
//   rise     - per-channel one-cycle 0->1 pulses
//   fall     - per-channel one-cycle 1->0 pulses
//   any_rise - OR of rise
//   rise_idx - lowest channel index with rise set; 0 when none
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS    = 32'sd4,
    parameter int                  DWELL_CNT   = DEF_DWELL_CNT,
    parameter int                  SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [CHANNELS-1:0] RESET_LEVEL = {CHANNELS{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           sig_in,
    output logic [CHANNELS-1:0]           sig_out,
    output logic [CHANNELS-1:0]           rise,
    output logic [CHANNELS-1:0]           fall,
    output logic                          any_rise,
    output logic [cnt_width(CHANNELS)-1:0] rise_idx
);

    localparam int IW = cnt_width(CHANNELS);

    if ((CHANNELS < 32'sd1) || (CHANNELS > 32'sd32) ||
        (DWELL_CNT < 32'sd1) || (SYNC_STAGES < 32'sd2)) begin : g_param_err
        $error("debounce_bank: illegal CHANNELS, DWELL_CNT or SYNC_STAGES");
    end

    logic [CHANNELS-1:0] rise_s;
    logic [IW-1:0]       idx_s;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_chan #(
            .DWELL_CNT   (DWELL_CNT),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_BIT   (RESET_LEVEL[g])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .sig_in  (sig_in[g]),
            .sig_out (sig_out[g]),
            .rise    (rise_s[g]),
            .fall    (fall[g])
        );
    end

    // Priority encoder: scanning from the top down lets the lowest set
    // channel be the last writer.
    always_comb begin
        idx_s = {IW{1'b0}};
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rise_s[i]) begin
                idx_s = IW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign rise     = rise_s;
    assign any_rise = |rise_s;
    assign rise_idx = idx_s;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
// Three builds share one stimulus stream: A (dwell 8, sync 2, reset 0000),
// B (dwell 8, sync 2, reset 1111) and C (dwell 1, sync 3, reset 0000).
// A reference model predicts every output after each edge and queues it; a
// monitor pops and compares on the falling edge.
module tb_debounce_bank;

    typedef struct packed {
        logic [3:0] so;
        logic [3:0] ri;
        logic [3:0] fa;
        logic       any;
        logic [1:0] idx;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig_in;

    logic [3:0] so_a, ri_a, fa_a, so_b, ri_b, fa_b, so_c, ri_c, fa_c;
    logic       any_a, any_b, any_c;
    logic [1:0] idx_a, idx_b, idx_c;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t exp_q [3][$];
    obs_t act   [3];

    int         dwell_c [3] = '{8, 8, 1};
    int         sync_c  [3] = '{2, 2, 3};
    logic [3:0] rlev_c  [3] = '{4'h0, 4'hF, 4'h0};
    string      name_c  [3] = '{"cfgA", "cfgB", "cfgC"};

    always #5 clk = ~clk;

    debounce_bank #(.CHANNELS(4), .DWELL_CNT(8), .SYNC_STAGES(2), .RESET_LEVEL(4'h0)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .sig_out(so_a), .rise(ri_a),
        .fall(fa_a), .any_rise(any_a), .rise_idx(idx_a));

    debounce_bank #(.CHANNELS(4), .DWELL_CNT(8), .SYNC_STAGES(2), .RESET_LEVEL(4'hF)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .sig_out(so_b), .rise(ri_b),
        .fall(fa_b), .any_rise(any_b), .rise_idx(idx_b));

    debounce_bank #(.CHANNELS(4), .DWELL_CNT(1), .SYNC_STAGES(3), .RESET_LEVEL(4'h0)) dut_c (
        .clk(clk), .rst(rst), .sig_in(sig_in), .sig_out(so_c), .rise(ri_c),
        .fall(fa_c), .any_rise(any_c), .rise_idx(idx_c));

    assign act[0] = '{so: so_a, ri: ri_a, fa: fa_a, any: any_a, idx: idx_a};
    assign act[1] = '{so: so_b, ri: ri_b, fa: fa_b, any: any_b, idx: idx_b};
    assign act[2] = '{so: so_c, ri: ri_c, fa: fa_c, any: any_c, idx: idx_c};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: the synchronized value is simply the input seen
    // sync_c edges earlier; a channel follows it once it has disagreed with
    // the debounced level for dwell_c consecutive edges.
    initial begin : model
        logic [3:0] hist  [3][3];
        logic [3:0] state [3];
        int         run   [3][4];
        logic [3:0] s;
        obs_t       e;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                e = '0;
                if (rst) begin
                    state[d] = rlev_c[d];
                    for (int j = 0; j < 3; j++) hist[d][j] = rlev_c[d];
                    for (int c = 0; c < 4; c++) run[d][c] = 0;
                end else begin
                    s = hist[d][sync_c[d] - 1];
                    hist[d][2] = hist[d][1];
                    hist[d][1] = hist[d][0];
                    hist[d][0] = sig_in;
                    for (int c = 0; c < 4; c++) begin
                        if (s[c] != state[d][c]) begin
                            run[d][c]++;
                            if (run[d][c] == dwell_c[d]) begin
                                state[d][c] = s[c];
                                run[d][c]   = 0;
                                if (s[c]) e.ri[c] = 1'b1;
                                else      e.fa[c] = 1'b1;
                            end
                        end else begin
                            run[d][c] = 0;
                        end
                    end
                end
                e.so  = state[d];
                e.any = (e.ri != 4'h0);
                for (int c = 0; c < 4; c++) begin
                    if (e.ri[c]) begin
                        e.idx = 2'(c);
                        break;
                    end
                end
                exp_q[d].push_back(e);
            end
        end
    end

    // Monitor: compare each build against its oldest queued prediction.
    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (exp_q[d].size() > 0) begin
                    e = exp_q[d].pop_front();
                    check(name_c[d], 32'(act[d]), 32'(e));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: directed scenarios followed by randomized bouncing.
    initial begin : stim
        int lat_a, lat_c;
        rst    = 1'b1;
        sig_in = 4'h0;
        idle(3);
        rst = 1'b0;
        idle(5);

        // Clean press on ch1 with explicit latency measurement.
        sig_in[1] = 1'b1;
        lat_a = -1;
        lat_c = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (so_a[1] && lat_a < 0) lat_a = n - 1;
            if (so_c[1] && lat_c < 0) lat_c = n - 1;
        end
        check("lat_press_a", 32'(lat_a), 32'd9);
        check("lat_press_c", 32'(lat_c), 32'd3);
        sig_in[1] = 1'b0;
        idle(20);

        // Bounce on ch0 every 3 cycles, then settle high.
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) sig_in[0] = ~sig_in[0];
            @(negedge clk);
        end
        sig_in[0] = 1'b1;
        idle(20);

        // Glitch on ch2 one cycle short of the dwell, then a real press.
        sig_in[2] = 1'b1;
        idle(7);
        sig_in[2] = 1'b0;
        idle(12);
        sig_in[2] = 1'b1;
        idle(15);

        // Simultaneous ch3 and ch1 presses.
        sig_in = 4'h0;
        idle(15);
        sig_in = 4'b1010;
        idle(15);

        // Reset in the middle of a dwell.
        sig_in = 4'h0;
        idle(15);
        sig_in[0] = 1'b1;
        idle(8);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(15);

        // Reset with all inputs high.
        sig_in = 4'hF;
        idle(15);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(15);

        // Single-cycle pulse on ch0.
        sig_in = 4'h0;
        idle(12);
        sig_in[0] = 1'b1;
        idle(1);
        sig_in[0] = 1'b0;
        idle(12);

        // Randomized bouncing with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 9) == 0) sig_in[c] = ~sig_in[c];
            end
            @(negedge clk);
        end
        rst = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-bit switch/button debouncer.
- Debounces CHANNELS independent asynchronous inputs (buttons, switches, mole-hit sensors) in the system clock domain.
- Adds an input synchronizer, a synchronous reset, per-channel rise/fall pulses and a lowest-index press encoder.
- Sits between board pins and the game FSM; the FSM consumes the level outputs or the one-cycle press pulses directly.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- DWELL_CNT, 16'd50000, consecutive cycles of stable disagreement required before a channel's output flips (>= 1).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer per channel (>= 2).
- RESET_LEVEL, {CHANNELS{1'b0}}, per-channel debounced state and synchronizer value after reset (CHANNELS bits).

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst, input, 1, reset, synchronous, active-high.
- sig_in, input, CHANNELS, raw asynchronous inputs.
- sig_out, output, CHANNELS, debounced levels.
- rise, output, CHANNELS, one-cycle pulse when the channel's sig_out goes 0->1.
- fall, output, CHANNELS, one-cycle pulse when the channel's sig_out goes 1->0.
- any_rise, output, 1, OR of rise.
- rise_idx, output, $clog2(CHANNELS) (min 1), index of the lowest-numbered channel with rise=1; 0 when any_rise=0.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - sync flops <= RESET_LEVEL; state <= RESET_LEVEL; counters <= 0; rise/fall <= 0.
  - sig_out = RESET_LEVEL, any_rise = 0, rise_idx = 0 in the following cycle.
  - rst overrides all other activity, including a flip pending on that same edge (the flip is lost).
- Synchronizer: each bit passes through SYNC_STAGES flops; s = last stage.
- Per-channel counter:
  - Width CW = max(1, $clog2(DWELL_CNT)).
  - If s != state and cnt == DWELL_CNT-1: state <= s, cnt <= 0.
  - Else if s != state: cnt <= cnt+1.
  - Else (s == state): cnt <= 0. Any glitch back to the current state restarts the dwell.
- Terminal compare: exact equality to DWELL_CNT-1, not a masked compare, so non-power-of-2 DWELL_CNT is exact.
- Counter range: cnt never exceeds DWELL_CNT-1 and never wraps.
- DWELL_CNT=1: flip on the first cycle of disagreement.
- Latency: a clean input step settled before edge k appears on sig_out after edge k+SYNC_STAGES+DWELL_CNT-1. That is SYNC_STAGES+DWELL_CNT edges inclusive of edge k.
- Pulses:
  - rise/fall are registered on the same edge as the state flip, so they are coincident with the first cycle of the new sig_out level.
  - Each pulse lasts exactly one cycle.
  - rise and fall are never both 1 on one channel.
- Simultaneous events:
  - Several channels may flip on the same edge; all their rise/fall bits assert together.
  - rise_idx selects the lowest-numbered channel among them.
- All outputs are registered or a pure function of registered rise. No combinational path from sig_in to any output.
- Channels are fully independent; there are no cross-channel interactions except any_rise/rise_idx.

Decomposition:
- Shared package debounce_pkg holds:
  - function cnt_width(dwell) returning max(1, $clog2(dwell));
  - constant DEF_DWELL_CNT = 50000;
  - constant DEF_SYNC_STAGES = 2.
- Sub-module debounce_chan holds one channel: synchronizer, counter, state, rise/fall.
  - debounce_chan has parameters DWELL_CNT, SYNC_STAGES, RESET_BIT.
  - debounce_bank instantiates debounce_chan in a generate loop and adds the priority encoder for any_rise/rise_idx.
- Elaboration check: fail if DWELL_CNT < 1, SYNC_STAGES < 2 or CHANNELS outside 1..32.

Test Plan:
- Test configuration: CHANNELS=4, DWELL_CNT=8, SYNC_STAGES=2, RESET_LEVEL=0 unless noted.
- Clean press: ch1 0->1 before edge 0, held -> sig_out[1]=1 after edge 9, not before; rise=4'b0010 for exactly that cycle; any_rise=1; rise_idx=1. Release -> fall[1] pulse after the same latency.
- Bounce: ch0 toggles every 3 cycles for 40 cycles, then holds 1 -> no change on sig_out[0] during bouncing; sig_out[0]=1 exactly 10 edges after the last transition.
- Glitch just short of dwell: ch2 high for 7 synchronized cycles then low -> sig_out[2] stays 0, no rise, counter back to 0. Then hold high for 8 -> flips.
- Simultaneous flips: ch3 and ch1 stepped on the same cycle -> rise=4'b1010 on one cycle; rise_idx=1; any_rise=1.
- Reset mid-dwell and reset levels:
  - rst=1 for 1 cycle when ch0 cnt=6 -> sig_out=0000, no rise; dwell restarts (sig_out[0] flips 10 edges after rst released if input held high).
  - Repeat with RESET_LEVEL=4'b1111 and inputs high -> sig_out=1111 immediately, no rise/fall pulses.
- DWELL_CNT=1, SYNC_STAGES=3 build: step ch0 -> sig_out[0] flips after 4 edges. Single-cycle input pulse -> flips up and then back.
